sweep_command_gen: RTL

Command-side controller for the 5-LED sweep display: debounces the player keys, maintains run/pause, and issues the direction code `state` plus the slow sweep tick. It drives the `state`, `start_stop` and clock inputs of the LED sweep display, and owns the end-of-sweep buzzer. Every sweep runs for exactly `SWEEP_TICKS` ticks, after which the block returns to idle.

---
 rtl/sweep_command_gen.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sweep_command_gen.sv
// -----------------------------------------------------------------------------
// sweep_command_gen
//
// Command-side controller for the 5-LED sweep display. It debounces the three
// player keys, keeps the run/pause flag, runs the IDLE / RUN_L / RUN_R
// direction FSM and produces the slow sweep tick. Every sweep lasts exactly
// SWEEP_TICKS ticks and then the block returns to idle, optionally sounding a
// short buzzer burst.
//
// Optional feature macro: SWEEP_BUZZER_EN
//   defined   : end-of-sweep beep generator is built
//   undefined : tone logic removed, o_buzzer tied low
//
// Parameters
//   TICK_DIV    clk_in cycles per sweep tick
//   DEB_CYCLES  cycles a key level must stay stable before it is accepted
//   SWEEP_TICKS ticks per sweep before returning to idle
//   BEEP_CYCLES buzzer burst length in cycles
//   TONE_DIV    half-period of the buzzer tone in cycles
//
// Ports
//   clk_in        in   system clock
//   reset         in   synchronous reset, active low
//   i_key_left    in   raw left key, active low, asynchronous
//   i_key_right   in   raw right key, active low, asynchronous
//   i_key_start   in   raw run/pause key, active low, asynchronous
//   o_state       out  direction code: 0 idle, 1 toward MSB, 2 toward LSB
//   o_start_stop  out  1 = running, 0 = paused
//   o_tick        out  one-cycle pulse at each sweep step
//   o_busy        out  high while o_state is non-zero
//   o_buzzer      out  square-wave tone
// -----------------------------------------------------------------------------
module sweep_command_gen #(
  parameter int TICK_DIV    = 47_000_000,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int SWEEP_TICKS = 4,
  parameter int BEEP_CYCLES = 12_500_000,
  parameter int TONE_DIV    = 25_000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       i_key_left,
  input  logic       i_key_right,
  input  logic       i_key_start,
  output logic [3:0] o_state,
  output logic       o_start_stop,
  output logic       o_tick,
  output logic       o_busy,
  output logic       o_buzzer
);

  // ---------------------------------------------------------------------------
  // Counter widths and terminal values
  // ---------------------------------------------------------------------------
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TCNT_W = $clog2(SWEEP_TICKS + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(SWEEP_TICKS - 1);
  localparam logic [TCNT_W-1:0] TCNT_FULL = TCNT_W'(SWEEP_TICKS);

  // Key index map
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_START = 2;

  // ---------------------------------------------------------------------------
  // Key conditioning: synchronizer, stability counter, press detector
  // ---------------------------------------------------------------------------
  logic [2:0] w_key_raw;
  logic [2:0] w_press;

  assign w_key_raw = {i_key_start, i_key_right, i_key_left};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      logic             r_deb;
      logic             r_press;
      logic [DEB_W-1:0] r_cnt;

      always_ff @(posedge clk_in) begin
        if (!reset) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_deb   <= 1'b1;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_key_raw[gi];
          r_sync2 <= r_sync1;
          r_press <= 1'b0;
          // r_sync1 != r_sync2 means the synchronized level changes on this
          // edge, so the stability count restarts together with that change.
          if (r_sync1 != r_sync2) begin
            r_cnt <= '0;
          end else if (r_cnt != DEB_LAST) begin
            r_cnt <= r_cnt + DEB_W'(1);
          end else begin
            // Level has been stable long enough: accept it. A 1->0 step of
            // the accepted level is a press.
            r_deb   <= r_sync2;
            r_press <= r_deb & ~r_sync2;
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Run / pause flag
  // ---------------------------------------------------------------------------
  logic r_start_stop;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_start_stop <= 1'b0;
    end else if (w_press[KEY_START]) begin
      r_start_stop <= ~r_start_stop;
    end
  end

  // ---------------------------------------------------------------------------
  // Direction FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_L = 2'd1,
    ST_RUN_R = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_busy;
  logic                r_tick;
  logic [DIV_W-1:0]    r_div;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                w_enter;
  logic                w_sweep_end;
  logic                w_run;

  // Divider only advances while running and a sweep is active.
  assign w_run = r_start_stop & r_busy;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_enter      = 1'b0;
    w_sweep_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A simultaneous left+right press is ambiguous and is dropped.
        if (r_start_stop && w_press[KEY_LEFT] && !w_press[KEY_RIGHT]) begin
          w_state_next = ST_RUN_L;
          w_enter      = 1'b1;
        end else if (r_start_stop && w_press[KEY_RIGHT] && !w_press[KEY_LEFT]) begin
          w_state_next = ST_RUN_R;
          w_enter      = 1'b1;
        end
      end
      ST_RUN_L, ST_RUN_R: begin
        // The tick is registered, so its effect lands one edge later. A tick
        // that was already issued is still honoured if a pause began on the
        // same edge; otherwise the step would be lost.
        if (r_tick && (r_tcnt == TCNT_LAST)) begin
          w_state_next = ST_IDLE;
          w_sweep_end  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tick divider and tick counter
  // ---------------------------------------------------------------------------
  // The tick is registered off the terminal count, which places the first
  // tick exactly TICK_DIV cycles after the state leaves idle and keeps every
  // later tick TICK_DIV running cycles apart.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      r_tcnt <= '0;
    end else begin
      r_tick <= w_run & (r_div == DIV_LAST);

      if (w_enter) begin
        r_div <= '0;
      end else if (w_run) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end

      // Saturating: the count is reloaded on the next sweep entry.
      if (w_enter) begin
        r_tcnt <= '0;
      end else if (r_tick && r_busy && (r_tcnt != TCNT_FULL)) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // End-of-sweep buzzer
  // ---------------------------------------------------------------------------
`ifdef SWEEP_BUZZER_EN
  localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  logic              r_beep_active;
  logic              r_buzzer;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic [TONE_W-1:0] r_tone_cnt;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_beep_active <= 1'b0;
      r_buzzer      <= 1'b0;
      r_beep_cnt    <= '0;
      r_tone_cnt    <= '0;
    end else if (w_enter) begin
      // A new sweep cuts any burst still sounding.
      r_beep_active <= 1'b0;
      r_buzzer      <= 1'b0;
      r_beep_cnt    <= '0;
      r_tone_cnt    <= '0;
    end else if (w_sweep_end) begin
      r_beep_active <= 1'b1;
      r_buzzer      <= 1'b0;
      r_beep_cnt    <= '0;
      r_tone_cnt    <= '0;
    end else if (r_beep_active) begin
      // Pause has no effect here: a burst in progress always completes.
      if (r_beep_cnt == BEEP_LAST) begin
        r_beep_active <= 1'b0;
        r_buzzer      <= 1'b0;
      end else begin
        r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
        if (r_tone_cnt == TONE_LAST) begin
          r_tone_cnt <= '0;
          r_buzzer   <= ~r_buzzer;
        end else begin
          r_tone_cnt <= r_tone_cnt + TONE_W'(1);
        end
      end
    end
  end

  assign o_buzzer = r_buzzer;
`else
  // Tone logic not built; keep the end-of-sweep strobe and the tone
  // parameters referenced so the build stays warning-free.
  logic w_unused_cfg;
  assign w_unused_cfg = w_sweep_end ^ (BEEP_CYCLES > 0) ^ (TONE_DIV > 0);
  assign o_buzzer     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_state      = {2'b00, r_state};
  assign o_start_stop = r_start_stop;
  assign o_tick       = r_tick;
  assign o_busy       = r_busy;

endmodule
